// File: rtl/reg_bank_pkg.sv
// ============================================================================
// Module : reg_bank_pkg
// Brief  : Shared FunSel encodings for the register bank and ALU controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_bank_pkg;

    typedef enum logic [2:0] {
        FS_DEC  = 3'b000,
        FS_INC  = 3'b001,
        FS_LOAD = 3'b010,
        FS_CLR  = 3'b011,
        FS_LOWZ = 3'b100,
        FS_LOW  = 3'b101,
        FS_HIGH = 3'b110,
        FS_SEXT = 3'b111
    } funsel_e;

endpackage

`default_nettype wire

// File: rtl/reg_bank_cell.sv
// ============================================================================
// Module : reg_cell
// Brief  : One WIDTH-bit register with inc/dec wrap or saturate detection.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_cell
    import reg_bank_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_en,
    input  funsel_e          i_funsel,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    always_comb begin
        w_next = r_q;
        w_wrap = 1'b0;
        case (i_funsel)
            FS_DEC: begin
                w_next = r_q - WIDTH'(1);
                if (~|r_q) begin
                    w_wrap = 1'b1;
                    if (SATURATE != 0) w_next = r_q;
                end
            end
            FS_INC: begin
                w_next = r_q + WIDTH'(1);
                if (&r_q) begin
                    w_wrap = 1'b1;
                    if (SATURATE != 0) w_next = r_q;
                end
            end
            FS_LOAD: w_next = i_data;
            FS_CLR:  w_next = '0;
            FS_LOWZ: w_next = {{(WIDTH-8){1'b0}}, i_data[7:0]};
            FS_LOW:  w_next = {r_q[WIDTH-1:8], i_data[7:0]};
            FS_HIGH: w_next = {i_data[7:0], r_q[WIDTH-9:0]};
            FS_SEXT: w_next = {{(WIDTH-8){i_data[7]}}, i_data[7:0]};
            default: w_next = r_q;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_q    <= RESET_VAL;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= i_en & w_wrap;
            if (i_en) r_q <= w_next;
        end
    end

    assign o_q    = r_q;
    assign o_wrap = r_wrap;

endmodule

`default_nettype wire

// File: rtl/reg_bank.sv
// ============================================================================
// Module : reg_bank
// Brief  : NREG-entry register bank with shared FunSel, two read ports, flags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               NREG      = 4,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              SELW      = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [NREG-1:0]  E,
    input  logic [2:0]       FunSel,
    input  logic [SELW-1:0]  OutASel,
    input  logic [SELW-1:0]  OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [NREG-1:0]  Zero,
    output logic [NREG-1:0]  Wrap
);

    logic [NREG-1:0][WIDTH-1:0] w_q;
    funsel_e                    w_funsel;

    assign w_funsel = funsel_e'(FunSel);

    for (genvar k = 0; k < NREG; k++) begin : g_cell
        reg_cell #(
            .WIDTH     (WIDTH),
            .SATURATE  (SATURATE),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .Clock    (Clock),
            .Reset    (Reset),
            .i_en     (E[k]),
            .i_funsel (w_funsel),
            .i_data   (I),
            .o_q      (w_q[k]),
            .o_wrap   (Wrap[k])
        );
        assign Zero[k] = ~|w_q[k];
    end

    // Selects with no matching register fall through to zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < NREG; k++) begin
            if (OutASel == SELW'(k)) OutA = w_q[k];
            if (OutBSel == SELW'(k)) OutB = w_q[k];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_bank.sv
// ============================================================================
// Module : tb_reg_bank
// Brief  : Three bank configurations driven in parallel against an array model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_bank;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] Idat  = '0;
    logic [3:0]  E     = '0;
    logic [2:0]  FunSel = '0;
    logic [1:0]  asel  = '0;
    logic [1:0]  bsel  = '0;

    logic [15:0] oa0, ob0, oa1, ob1;
    logic [31:0] oa2, ob2;
    logic [3:0]  z0, w0, z1, w1;
    logic [2:0]  z2, w2;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 Clock = ~Clock;

    reg_bank u0 (
        .Clock(Clock), .Reset(Reset), .I(Idat[15:0]), .E(E), .FunSel(FunSel),
        .OutASel(asel), .OutBSel(bsel), .OutA(oa0), .OutB(ob0), .Zero(z0), .Wrap(w0)
    );

    reg_bank #(.SATURATE(1), .RESET_VAL(16'h00A5)) u1 (
        .Clock(Clock), .Reset(Reset), .I(Idat[15:0]), .E(E), .FunSel(FunSel),
        .OutASel(asel), .OutBSel(bsel), .OutA(oa1), .OutB(ob1), .Zero(z1), .Wrap(w1)
    );

    reg_bank #(.WIDTH(32), .NREG(3)) u2 (
        .Clock(Clock), .Reset(Reset), .I(Idat), .E(E[2:0]), .FunSel(FunSel),
        .OutASel(asel), .OutBSel(bsel), .OutA(oa2), .OutB(ob2), .Zero(z2), .Wrap(w2)
    );

    int          CW [3] = '{16, 16, 32};
    int          CS [3] = '{0, 1, 0};
    int          CN [3] = '{4, 4, 3};
    logic [63:0] CR [3] = '{64'h0, 64'h00A5, 64'h0};

    logic [63:0] m_q [3][4];
    logic [3:0]  m_w [3];

    function automatic logic [63:0] nxt(input int a, input logic [63:0] q,
                                        input logic [2:0] fs, input logic [31:0] d,
                                        output bit wr);
        logic [63:0] mask = (64'd1 << CW[a]) - 64'd1;
        logic [63:0] lo   = {56'd0, d[7:0]};
        wr = 1'b0;
        case (fs)
            3'd0: if (q == 0) begin wr = 1; return (CS[a] != 0) ? q : mask; end
                  else return q - 1;
            3'd1: if (q == mask) begin wr = 1; return (CS[a] != 0) ? q : 64'd0; end
                  else return q + 1;
            3'd2: return {32'd0, d} & mask;
            3'd3: return 64'd0;
            3'd4: return lo;
            3'd5: return (q & ~64'hFF) | lo;
            3'd6: return ((q & ~(64'hFF << (CW[a] - 8))) | (lo << (CW[a] - 8))) & mask;
            default: return d[7] ? ((mask & ~64'hFF) | lo) : lo;
        endcase
    endfunction

    always @(posedge Clock or posedge Reset) begin
        bit wr;
        if (Reset) begin
            for (int a = 0; a < 3; a++) begin
                for (int k = 0; k < 4; k++) m_q[a][k] = CR[a];
                m_w[a] = '0;
            end
        end else begin
            for (int a = 0; a < 3; a++) begin
                m_w[a] = '0;
                for (int k = 0; k < CN[a]; k++) begin
                    if (E[k]) begin
                        m_q[a][k] = nxt(a, m_q[a][k], FunSel, Idat, wr);
                        m_w[a][k] = wr;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_out(input int a, input logic [1:0] s);
        return (int'(s) < CN[a]) ? m_q[a][s] : 64'd0;
    endfunction

    function automatic logic [63:0] exp_zero(input int a);
        logic [63:0] z = '0;
        for (int k = 0; k < CN[a]; k++) z[k] = (m_q[a][k] == 0);
        return z;
    endfunction

    always @(negedge Clock) begin
        if (chk_en) begin
            check("u0.OutA", {48'd0, oa0}, exp_out(0, asel));
            check("u0.OutB", {48'd0, ob0}, exp_out(0, bsel));
            check("u0.Zero", {60'd0, z0}, exp_zero(0));
            check("u0.Wrap", {60'd0, w0}, {60'd0, m_w[0]});
            check("u1.OutA", {48'd0, oa1}, exp_out(1, asel));
            check("u1.OutB", {48'd0, ob1}, exp_out(1, bsel));
            check("u1.Zero", {60'd0, z1}, exp_zero(1));
            check("u1.Wrap", {60'd0, w1}, {60'd0, m_w[1]});
            check("u2.OutA", {32'd0, oa2}, exp_out(2, asel));
            check("u2.OutB", {32'd0, ob2}, exp_out(2, bsel));
            check("u2.Zero", {61'd0, z2}, exp_zero(2));
            check("u2.Wrap", {61'd0, w2}, {60'd0, m_w[2]});
        end
    end

    // Inputs are applied at the next rising edge; E is dropped right after it.
    task automatic op(input logic [3:0] e, input logic [2:0] fs, input logic [31:0] d,
                      input logic [1:0] sa, input logic [1:0] sb);
        @(negedge Clock); #1;
        E = e; FunSel = fs; Idat = d; asel = sa; bsel = sb;
        @(posedge Clock); #1;
        E = '0;
    endtask

    initial begin
        #1 Reset = 1'b1;
        #1;
        check("reset u0.OutA", {48'd0, oa0}, 64'h0);
        check("reset u1.OutA", {48'd0, oa1}, 64'hA5);
        check("reset u1.Zero", {60'd0, z1}, 64'h0);
        repeat (2) @(posedge Clock);
        @(negedge Clock); #1 Reset = 1'b0;
        chk_en = 1'b1;

        op(4'b0001, 3'b010, 32'h0000FFFF, 2'd0, 2'd0);
        op(4'b0001, 3'b001, 32'h0, 2'd0, 2'd0);
        check("inc wrap OutA", {48'd0, oa0}, 64'h0);
        check("inc wrap Zero0", {63'd0, z0[0]}, 64'h1);
        check("inc wrap Wrap0", {63'd0, w0[0]}, 64'h1);
        check("sat inc hold", {48'd0, oa1}, 64'hFFFF);
        check("w32 inc", {32'd0, oa2}, 64'h10000);
        @(posedge Clock); #1;
        check("wrap one cycle", {63'd0, w0[0]}, 64'h0);

        op(4'b0010, 3'b011, 32'h0, 2'd1, 2'd1);
        op(4'b0010, 3'b000, 32'h0, 2'd1, 2'd1);
        check("sat dec1 R1", {48'd0, oa1}, 64'h0);
        check("sat dec1 Wrap1", {63'd0, w1[1]}, 64'h1);
        op(4'b0010, 3'b000, 32'h0, 2'd1, 2'd1);
        check("sat dec2 R1", {48'd0, oa1}, 64'h0);
        check("sat dec2 Wrap1", {63'd0, w1[1]}, 64'h1);
        check("wrap dec2 R1", {48'd0, oa0}, 64'hFFFE);

        op(4'b0101, 3'b111, 32'h00000080, 2'd0, 2'd2);
        check("sext R0", {48'd0, oa0}, 64'hFF80);
        check("sext R2", {48'd0, ob0}, 64'hFF80);
        check("sext w32 R0", {32'd0, oa2}, 64'hFFFFFF80);

        op(4'b1100, 3'b010, 32'h12345678, 2'd2, 2'd3);
        op(4'b1100, 3'b110, 32'h000000AB, 2'd2, 2'd3);
        check("high w32", {32'd0, oa2}, 64'hAB345678);
        check("high w16 R3", {48'd0, ob0}, 64'hAB78);
        op(4'b1100, 3'b100, 32'h000000CD, 2'd2, 2'd3);
        check("lowz w32", {32'd0, oa2}, 64'hCD);

        op(4'b0000, 3'b010, 32'h0, 2'd3, 2'd3);
        check("sel out of range", {32'd0, oa2}, 64'h0);
        check("sel R3 u0", {48'd0, oa0}, 64'hCD);

        @(negedge Clock); #1;
        E = 4'b0100; FunSel = 3'b010; Idat = 32'h1234; bsel = 2'd2;
        #1 check("no write-through", {48'd0, ob0}, 64'hCD);
        @(posedge Clock); #1;
        E = '0;
        check("write visible", {48'd0, ob0}, 64'h1234);

        op(4'b0001, 3'b010, 32'h0000FFFF, 2'd0, 2'd0);
        op(4'b0001, 3'b001, 32'h0, 2'd0, 2'd0);
        check("pre-reset Wrap0", {63'd0, w0[0]}, 64'h1);
        #1 Reset = 1'b1;
        #1;
        check("async Wrap", {60'd0, w0}, 64'h0);
        check("async u1.OutA", {48'd0, oa1}, 64'hA5);
        check("async u1.Zero", {60'd0, z1}, 64'h0);
        check("async u0.Zero", {60'd0, z0}, 64'hF);
        E = 4'b1111; FunSel = 3'b001;
        @(posedge Clock); #1;
        check("reset edge hold", {48'd0, oa1}, 64'hA5);
        check("reset edge Wrap", {60'd0, w1}, 64'h0);
        @(negedge Clock); #1;
        Reset = 1'b0; E = '0;
        op(4'b0001, 3'b001, 32'h0, 2'd0, 2'd0);
        check("post-reset u1 inc", {48'd0, oa1}, 64'hA6);
        check("post-reset u0 inc", {48'd0, oa0}, 64'h1);

        @(negedge Clock); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
